// File: rtl/chan_fifo_bridge_if.sv
// Host channel and application byte-stream signals of chan_fifo_bridge.
// slave = bridge side, master = host/application side.
interface chan_fifo_bridge_if;
    logic [6:0] chanAddr_in;
    logic [7:0] h2fData_in;
    logic       h2fValid_in;
    logic       h2fReady_out;
    logic [7:0] f2hData_out;
    logic       f2hValid_out;
    logic       f2hReady_in;
    logic [7:0] appRxData_out;
    logic       appRxValid_out;
    logic       appRxReady_in;
    logic [7:0] appTxData_in;
    logic       appTxValid_in;
    logic       appTxReady_out;

    modport slave (
        input  chanAddr_in, h2fData_in, h2fValid_in, f2hReady_in,
               appRxReady_in, appTxData_in, appTxValid_in,
        output h2fReady_out, f2hData_out, f2hValid_out,
               appRxData_out, appRxValid_out, appTxReady_out
    );

    modport master (
        output chanAddr_in, h2fData_in, h2fValid_in, f2hReady_in,
               appRxReady_in, appTxData_in, appTxValid_in,
        input  h2fReady_out, f2hData_out, f2hValid_out,
               appRxData_out, appRxValid_out, appTxReady_out
    );
endinterface

// File: rtl/chan_fifo_bridge.sv
// Channel-addressed host bridge: channel 0 feeds the RX FIFO, channel 1 drains the TX FIFO.
// Define CHAN_FIFO_STATUS_EN to make channel 2 a status read (txEmpty, RX occupancy).
module chan_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input logic               clk_in,
    input logic               reset_in,
    chan_fifo_bridge_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];
    logic [DEPTH_LOG2:0] rx_wr, rx_rd, tx_wr, tx_rd;
    logic rx_full, rx_empty, tx_full, tx_empty;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic ch_rx, ch_tx;
    logic [7:0] f2h_data;
    logic       f2h_valid;

    assign ch_rx = (bus.chanAddr_in == 7'd0);
    assign ch_tx = (bus.chanAddr_in == 7'd1);

    // Full when indices match but wrap bits differ; empty when pointers are equal.
    assign rx_empty = (rx_wr == rx_rd);
    assign tx_empty = (tx_wr == tx_rd);
    assign rx_full  = (rx_wr[DEPTH_LOG2] != rx_rd[DEPTH_LOG2]) &&
                      (rx_wr[DEPTH_LOG2-1:0] == rx_rd[DEPTH_LOG2-1:0]);
    assign tx_full  = (tx_wr[DEPTH_LOG2] != tx_rd[DEPTH_LOG2]) &&
                      (tx_wr[DEPTH_LOG2-1:0] == tx_rd[DEPTH_LOG2-1:0]);

    assign rx_push = ch_rx && bus.h2fValid_in && !rx_full;
    assign rx_pop  = !rx_empty && bus.appRxReady_in;
    assign tx_push = bus.appTxValid_in && !tx_full;
    assign tx_pop  = ch_tx && !tx_empty && bus.f2hReady_in;

    // Host writes to any channel other than 0 are swallowed, so never stall them.
    assign bus.h2fReady_out   = ch_rx ? !rx_full : 1'b1;
    assign bus.appRxValid_out = !rx_empty;
    assign bus.appRxData_out  = rx_empty ? 8'h00 : rx_mem[rx_rd[DEPTH_LOG2-1:0]];
    assign bus.appTxReady_out = !tx_full;

    always_comb begin
        f2h_valid = 1'b1;
        f2h_data  = 8'h00;
        if (ch_tx) begin
            f2h_valid = !tx_empty;
            f2h_data  = tx_empty ? 8'h00 : tx_mem[tx_rd[DEPTH_LOG2-1:0]];
        end
`ifdef CHAN_FIFO_STATUS_EN
        else if (bus.chanAddr_in == 7'd2) begin
            f2h_data[7]            = tx_empty;
            f2h_data[DEPTH_LOG2:0] = rx_wr - rx_rd;
        end
`endif
    end

    assign bus.f2hValid_out = f2h_valid;
    assign bus.f2hData_out  = f2h_data;

    // Storage is deliberately left unreset; emptiness is carried by the pointers alone.
    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wr[DEPTH_LOG2-1:0]] <= bus.h2fData_in;
        if (tx_push) tx_mem[tx_wr[DEPTH_LOG2-1:0]] <= bus.appTxData_in;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            rx_wr <= '0;
            rx_rd <= '0;
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + PTR_ONE;
            if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
            if (tx_push) tx_wr <= tx_wr + PTR_ONE;
            if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
        end
    end
endmodule

// File: tb/tb_chan_fifo_bridge.sv
// Directed scoreboard bench for chan_fifo_bridge (DEPTH_LOG2 = 4).
module tb_chan_fifo_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] status_exp;

    always #5 clk = ~clk;

    chan_fifo_bridge_if bus();

    chan_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk_in  (clk),
        .reset_in(rst),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; leaves the bench at the next posedge+1.
    task automatic host_write(input logic [6:0] ch, input logic [7:0] d);
        logic exp_rdy;
        exp_rdy = (ch != 7'd0) || (rxq.size() < 16);
        bus.chanAddr_in = ch;
        bus.h2fData_in  = d;
        bus.h2fValid_in = 1'b1;
        #1 chk("h2f_ready", bus.h2fReady_out, exp_rdy);
        @(posedge clk);
        if (ch == 7'd0 && exp_rdy) rxq.push_back(d);
        #1 bus.h2fValid_in = 1'b0;
    endtask

    task automatic app_pop(input string tag);
        chk({tag, "_valid"}, bus.appRxValid_out, rxq.size() != 0);
        if (rxq.size() != 0) chk({tag, "_data"}, bus.appRxData_out, rxq[0]);
        bus.appRxReady_in = 1'b1;
        @(posedge clk);
        if (rxq.size() != 0) void'(rxq.pop_front());
        #1 bus.appRxReady_in = 1'b0;
    endtask

    task automatic app_push(input logic [7:0] d);
        bus.appTxData_in  = d;
        bus.appTxValid_in = 1'b1;
        #1 chk("app_tx_ready", bus.appTxReady_out, txq.size() < 16);
        @(posedge clk);
        if (txq.size() < 16) txq.push_back(d);
        #1 bus.appTxValid_in = 1'b0;
    endtask

    initial begin
`ifdef CHAN_FIFO_STATUS_EN
        status_exp = 8'h85;
`else
        status_exp = 8'h00;
`endif
        bus.chanAddr_in = 7'd0;  bus.h2fData_in = 8'h00; bus.h2fValid_in = 1'b0;
        bus.f2hReady_in = 1'b0;  bus.appRxReady_in = 1'b0;
        bus.appTxData_in = 8'h00; bus.appTxValid_in = 1'b0;

        // Reset state
        #1;
        chk("rst_rx_valid", bus.appRxValid_out, 1'b0);
        chk("rst_rx_data", bus.appRxData_out, 8'h00);
        chk("rst_tx_ready", bus.appTxReady_out, 1'b1);
        chk("rst_h2f_ready_ch0", bus.h2fReady_out, 1'b1);
        bus.chanAddr_in = 7'd1;
        #1 chk("rst_f2h_valid_ch1", bus.f2hValid_out, 1'b0);
        bus.chanAddr_in = 7'd0;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;

        // Three pushes; first byte visible one cycle after its push edge
        host_write(7'd0, 8'h11);
        chk("lat1_valid", bus.appRxValid_out, 1'b1);
        chk("lat1_data", bus.appRxData_out, 8'h11);
        host_write(7'd0, 8'h22);
        host_write(7'd0, 8'h33);
        repeat (3) app_pop("rx_pop");
        chk("rx_drained_valid", bus.appRxValid_out, 1'b0);
        chk("rx_drained_data", bus.appRxData_out, 8'h00);

        // Simultaneous push and pop on one edge
        host_write(7'd0, 8'h40);
        chk("sim_head0", bus.appRxData_out, rxq[0]);
        bus.chanAddr_in = 7'd0; bus.h2fData_in = 8'h41; bus.h2fValid_in = 1'b1;
        bus.appRxReady_in = 1'b1;
        #1 chk("sim_h2f_ready", bus.h2fReady_out, 1'b1);
        @(posedge clk);
        void'(rxq.pop_front()); rxq.push_back(8'h41);
        #1 bus.h2fValid_in = 1'b0; bus.appRxReady_in = 1'b0;
        chk("sim_valid", bus.appRxValid_out, 1'b1);
        chk("sim_head1", bus.appRxData_out, rxq[0]);
        app_pop("sim_pop");

        // Fill to full, hold 17th byte, one pop releases it (spans pointer wrap)
        for (int i = 0; i < 16; i++) host_write(7'd0, 8'hC0 + 8'(i));
        bus.chanAddr_in = 7'd0; bus.h2fData_in = 8'hEE; bus.h2fValid_in = 1'b1;
        #1 chk("full_h2f_ready", bus.h2fReady_out, 1'b0);
        chk("full_head", bus.appRxData_out, rxq[0]);
        bus.appRxReady_in = 1'b1;
        @(posedge clk);
        void'(rxq.pop_front());
        #1 bus.appRxReady_in = 1'b0;
        chk("after_pop_h2f_ready", bus.h2fReady_out, 1'b1);
        @(posedge clk);
        rxq.push_back(8'hEE);
        #1 bus.h2fValid_in = 1'b0;
        chk("refull_h2f_ready", bus.h2fReady_out, 1'b0);
        while (rxq.size() != 0) app_pop("full_drain");
        chk("full_drain_empty", bus.appRxValid_out, 1'b0);

        // TX path through channel 1
        app_push(8'hA5);
        app_push(8'h5A);
        bus.chanAddr_in = 7'd1; bus.f2hReady_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("f2h_valid", bus.f2hValid_out, 1'b1);
            chk("f2h_data", bus.f2hData_out, txq[0]);
            @(posedge clk);
            void'(txq.pop_front());
        end
        #1 chk("f2h_empty_valid", bus.f2hValid_out, 1'b0);
        chk("f2h_empty_data", bus.f2hData_out, 8'h00);
        bus.f2hReady_in = 1'b0;

        // Status channel: 5 bytes in RX, TX empty
        for (int i = 0; i < 5; i++) host_write(7'd0, 8'h50 + 8'(i));
        bus.chanAddr_in = 7'd2; bus.f2hReady_in = 1'b1;
        #1 chk("ch2_valid", bus.f2hValid_out, 1'b1);
        chk("ch2_data", bus.f2hData_out, status_exp);
        @(posedge clk);
        #1 chk("ch2_reread", bus.f2hData_out, status_exp);
        bus.f2hReady_in = 1'b0;
        chk("ch2_rx_head", bus.appRxData_out, rxq[0]);

        // Asynchronous reset between edges with 3 bytes queued
        repeat (2) app_pop("pre_rst_pop");
        #2 rst = 1'b1;
        #1 chk("async_rst_valid", bus.appRxValid_out, 1'b0);
        chk("async_rst_data", bus.appRxData_out, 8'h00);
        #1 rst = 1'b0;
        rxq.delete(); txq.delete();
        @(posedge clk); #1;
        host_write(7'd0, 8'h7E);
        chk("post_rst_valid", bus.appRxValid_out, 1'b1);
        chk("post_rst_head", bus.appRxData_out, 8'h7E);
        app_pop("post_rst_pop");

        // Unmapped channel 9: write swallowed, read returns 0x00
        host_write(7'd9, 8'hFF);
        bus.chanAddr_in = 7'd9; bus.f2hReady_in = 1'b1;
        #1 chk("ch9_valid", bus.f2hValid_out, 1'b1);
        chk("ch9_data", bus.f2hData_out, 8'h00);
        @(posedge clk);
        #1 bus.f2hReady_in = 1'b0;
        chk("ch9_rx_unchanged", bus.appRxValid_out, 1'b0);
        chk("ch9_tx_ready", bus.appTxReady_out, 1'b1);
        bus.chanAddr_in = 7'd1;
        #1 chk("ch9_tx_unchanged", bus.f2hValid_out, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/chan_fifo_bridge.md
CHAN_FIFO_BRIDGE -- requirements
Module: chan_fifo_bridge

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4: log2 of each FIFO depth; legal range 1..6.
REQ-002 SHALL have port clk_in, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_in, input, 1: reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port chanAddr_in, input, 7: currently selected host channel (0-127).
REQ-005 SHALL have port h2fData_in, input, 8: host-to-FPGA data byte.
REQ-006 SHALL have port h2fValid_in, input, 1: host byte present this cycle.
REQ-007 SHALL have port h2fReady_out, output, 1: bridge accepts h2f byte this edge.
REQ-008 SHALL have port f2hData_out, output, 8: FPGA-to-host data byte.
REQ-009 SHALL have port f2hValid_out, output, 1: f2h byte available.
REQ-010 SHALL have port f2hReady_in, input, 1: host consumes f2h byte this edge.
REQ-011 SHALL have port appRxData_out, output, 8: head of RX FIFO to application.
REQ-012 SHALL have port appRxValid_out, output, 1: RX FIFO non-empty.
REQ-013 SHALL have port appRxReady_in, input, 1: application pops RX head this edge.
REQ-014 SHALL have port appTxData_in, input, 8: application byte for host.
REQ-015 SHALL have port appTxValid_in, input, 1: application byte present.
REQ-016 SHALL have port appTxReady_out, output, 1: TX FIFO not full.

Function
REQ-017 SHALL contain two FIFOs (RX: host->app, TX: app->host), each 2**DEPTH_LOG2 entries, read/write pointers DEPTH_LOG2+1 bits with wrap bit; full = same index, differing wrap bit; empty = pointers equal.
REQ-018 SHALL decode channels combinationally from chanAddr_in: 0 = RX data, 1 = TX data, 2 = status, 3-127 = unmapped.
REQ-019 SHALL drive h2fReady_out = !rxFull on channel 0 and 1 on all other channels; writes to channels 1-127 are accepted and discarded.
REQ-020 SHALL push h2fData_in into RX on an edge with channel 0, h2fValid_in=1, h2fReady_out=1; when full, no push, host stalls.
REQ-021 SHALL present RX first-word-fall-through: appRxValid_out = !rxEmpty, appRxData_out = head entry, 0x00 when empty; pop on appRxValid_out & appRxReady_in.
REQ-022 SHALL make a pushed byte visible on appRxValid_out/appRxData_out one cycle after the push edge (latency 1).
REQ-023 SHALL allow simultaneous push and pop in one edge (count unchanged) when neither full nor empty blocks it; when full, pop frees space visible next cycle only.
REQ-024 SHALL drive appTxReady_out = !txFull and push appTxData_in on appTxValid_in & appTxReady_out.
REQ-025 SHALL on channel 1 drive f2hValid_out = !txEmpty, f2hData_out = TX head (0x00 when empty), pop on f2hValid_out & f2hReady_in.
REQ-026 SHALL on channel 3-127 drive f2hValid_out=1, f2hData_out=0x00; reads have no side effects.
REQ-027 SHALL never pop TX when channel is not 1, and never push RX when channel is not 0.
REQ-028 SHALL wrap pointers modulo 2**(DEPTH_LOG2+1) without loss across wrap-around.

Reset
REQ-029 SHALL on reset_in=1 asynchronously clear all pointers, flushing both FIFOs; FIFO storage is not reset.
REQ-030 SHALL during/after reset present appRxValid_out=0, appRxData_out=0x00, appTxReady_out=1, f2hValid_out=0 on channel 1, h2fReady_out=1 on channel 0.
REQ-031 SHALL discard any byte in flight when reset asserts mid-transfer; first post-reset push lands in entry 0.

Configuration
REQ-032 SHALL with macro CHAN_FIFO_STATUS_EN defined implement channel 2 read: f2hValid_out=1, f2hData_out bit7 = txEmpty, bits[DEPTH_LOG2:0] = RX occupancy count, other bits 0; reads side-effect free.
REQ-033 SHALL without CHAN_FIFO_STATUS_EN treat channel 2 exactly as unmapped (REQ-026).

Verification
REQ-034 SHALL cover: reset, channel 0, push 0x11,0x22,0x33 with appRxReady_in=0 -> appRxValid_out=1 one cycle after first push, appRxData_out=0x11; then pops yield 0x22,0x33, then valid=0.
REQ-035 SHALL cover: DEPTH_LOG2=4, 16 pushes on channel 0 -> h2fReady_out=0; 17th byte held; one app pop -> h2fReady_out=1 next cycle, 17th byte accepted.
REQ-036 SHALL cover: app pushes 0xA5,0x5A; host reads channel 1 with f2hReady_in=1 -> 0xA5 then 0x5A, then f2hValid_out=0, f2hData_out=0x00.
REQ-037 SHALL cover: with CHAN_FIFO_STATUS_EN, 5 bytes in RX, TX empty, read channel 2 -> 0x85; without macro -> 0x00.
REQ-038 SHALL cover: 3 bytes in RX, reset_in pulsed asynchronously between edges -> appRxValid_out=0 immediately; next push 0x7E appears at head.
REQ-039 SHALL cover: write 0xFF to channel 9 and read channel 9 -> h2fReady_out=1, no FIFO change, read returns 0x00 with f2hValid_out=1.
